// File: rtl/ps2_bbc_keymatrix_pkg.sv
// Shared types and constants for the PS/2 set-2 to BBC keyboard matrix decoder.
// Holds FSM encoding, matrix geometry and the scan code prefix/status bytes.
package ps2_bbc_keymatrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    localparam int NUM_COLS = 10;
    localparam int NUM_ROWS = 8;

    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] KEY_F12 = 8'h07;

    // Keyboard self-test pass, ACK and resend carry no key information.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE);
    endfunction

endpackage

// File: rtl/ps2_bbc_keymatrix_if.sv
// Byte-in / matrix-read bundle between the PS/2 receiver, VIA keyboard logic and the decoder.
// Master is the system side; slave is the key matrix.
interface ps2_bbc_keymatrix_if;
    logic [7:0] PS2_DATA;
    logic       PS2_DONE;
    logic [3:0] KB_COL;
    logic [2:0] KB_ROW;
    logic       KEY_PRESSED;
    logic       COL_ACTIVE;
    logic       ANY_KEY;

    modport master (
        output PS2_DATA, PS2_DONE, KB_COL, KB_ROW,
        input  KEY_PRESSED, COL_ACTIVE, ANY_KEY
    );

    modport slave (
        input  PS2_DATA, PS2_DONE, KB_COL, KB_ROW,
        output KEY_PRESSED, COL_ACTIVE, ANY_KEY
    );
endinterface

// File: rtl/ps2_bbc_scancode_map.sv
// Combinational PS/2 set-2 scan code to BBC matrix position lookup.
// Table entries are written as 7'h<row><col>; F12 is not here, it drives BREAK.
module ps2_bbc_scancode_map (
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic [2:0] o_row,
    output logic [3:0] o_col
);
    logic [8:0] w_key;
    logic [6:0] w_rc;

    assign w_key = {i_ext, i_code};

    always_comb begin
        o_hit = 1'b1;
        w_rc  = 7'h00;
        case (w_key)
            9'h012, 9'h059: w_rc = 7'h00;
            9'h014, 9'h114: w_rc = 7'h01;
            9'h015:         w_rc = 7'h10;
            9'h026, 9'h07A: w_rc = 7'h11;
            9'h025, 9'h06B: w_rc = 7'h12;
            9'h02E, 9'h073: w_rc = 7'h13;
            9'h00C:         w_rc = 7'h14;
            9'h03E, 9'h075: w_rc = 7'h15;
            9'h083:         w_rc = 7'h16;
            9'h04E:         w_rc = 7'h17;
            9'h055:         w_rc = 7'h18;
            9'h16B:         w_rc = 7'h19;
            9'h009:         w_rc = 7'h20;
            9'h01D:         w_rc = 7'h21;
            9'h024:         w_rc = 7'h22;
            9'h02C:         w_rc = 7'h23;
            9'h03D, 9'h06C: w_rc = 7'h24;
            9'h043:         w_rc = 7'h25;
            9'h046, 9'h07D: w_rc = 7'h26;
            9'h045, 9'h070: w_rc = 7'h27;
            9'h05D:         w_rc = 7'h28;
            9'h172:         w_rc = 7'h29;
            9'h016, 9'h069: w_rc = 7'h30;
            9'h01E, 9'h072: w_rc = 7'h31;
            9'h023:         w_rc = 7'h32;
            9'h02D:         w_rc = 7'h33;
            9'h036, 9'h074: w_rc = 7'h34;
            9'h03C:         w_rc = 7'h35;
            9'h044:         w_rc = 7'h36;
            9'h04D:         w_rc = 7'h37;
            9'h054:         w_rc = 7'h38;
            9'h175:         w_rc = 7'h39;
            9'h058:         w_rc = 7'h40;
            9'h01C:         w_rc = 7'h41;
            9'h022:         w_rc = 7'h42;
            9'h02B:         w_rc = 7'h43;
            9'h035:         w_rc = 7'h44;
            9'h03B:         w_rc = 7'h45;
            9'h042:         w_rc = 7'h46;
            9'h00E:         w_rc = 7'h47;
            9'h052:         w_rc = 7'h48;
            9'h05A, 9'h15A: w_rc = 7'h49;
            9'h011:         w_rc = 7'h50;
            9'h01B:         w_rc = 7'h51;
            9'h021:         w_rc = 7'h52;
            9'h034:         w_rc = 7'h53;
            9'h033:         w_rc = 7'h54;
            9'h031:         w_rc = 7'h55;
            9'h04B:         w_rc = 7'h56;
            9'h04C:         w_rc = 7'h57;
            9'h05B:         w_rc = 7'h58;
            9'h066, 9'h171: w_rc = 7'h59;
            9'h00D:         w_rc = 7'h60;
            9'h01A:         w_rc = 7'h61;
            9'h029:         w_rc = 7'h62;
            9'h02A:         w_rc = 7'h63;
            9'h032:         w_rc = 7'h64;
            9'h03A:         w_rc = 7'h65;
            9'h041:         w_rc = 7'h66;
            9'h049:         w_rc = 7'h67;
            9'h04A:         w_rc = 7'h68;
            9'h169:         w_rc = 7'h69;
            9'h076:         w_rc = 7'h70;
            9'h005:         w_rc = 7'h71;
            9'h006:         w_rc = 7'h72;
            9'h004:         w_rc = 7'h73;
            9'h003:         w_rc = 7'h74;
            9'h00B:         w_rc = 7'h75;
            9'h00A:         w_rc = 7'h76;
            9'h001:         w_rc = 7'h77;
            9'h061:         w_rc = 7'h78;
            9'h174:         w_rc = 7'h79;
            default:        o_hit = 1'b0;
        endcase
    end

    assign o_row = w_rc[6:4];
    assign o_col = w_rc[3:0];

endmodule

// File: rtl/ps2_bbc_keymatrix.sv
// PS/2 set-2 make/break decoder driving the 10x8 BBC keyboard matrix, BREAK and column activity.
// Bytes land in the matrix one cycle after consumption; reads are combinational from registers.
module ps2_bbc_keymatrix
    import ps2_bbc_keymatrix_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic                 clk_en,
    input  logic [7:0]           DIP,
    output logic                 nBREAK,
    ps2_bbc_keymatrix_if.slave   kb
);
    state_t                              r_state;
    logic [2:0]                          r_skip_cnt;
    logic [15:0]                         r_tmo_cnt;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]   r_matrix;
    logic                                r_nbreak;

    logic                                w_ext;
    logic                                w_hit;
    logic [2:0]                          w_row;
    logic [3:0]                          w_col;
    logic [7:0]                          w_byte;

    assign w_byte = kb.PS2_DATA;
    assign w_ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

    ps2_bbc_scancode_map u_map (
        .i_ext  (w_ext),
        .i_code (w_byte),
        .o_hit  (w_hit),
        .o_row  (w_row),
        .o_col  (w_col)
    );

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_matrix   <= '0;
            r_nbreak   <= 1'b1;
        end else if (clk_en) begin
            if (kb.PS2_DONE) begin
                r_tmo_cnt <= '0;
                // Overrun/error from the keyboard: state is unknowable, drop every key.
                if (w_byte == BYTE_00 || w_byte == BYTE_FF) begin
                    r_matrix   <= '0;
                    r_nbreak   <= 1'b1;
                    r_state    <= ST_IDLE;
                    r_skip_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_byte == BYTE_F0) begin
                                r_state <= ST_BRK;
                            end else if (w_byte == BYTE_E0) begin
                                r_state <= ST_EXT;
                            end else if (w_byte == BYTE_E1) begin
                                r_state    <= ST_SKIP;
                                r_skip_cnt <= 3'd7;
                            end else if (w_byte == KEY_F12) begin
                                r_nbreak <= 1'b0;
                            end else if (!is_status_byte(w_byte) && w_hit) begin
                                r_matrix[w_col][w_row] <= 1'b1;
                            end
                        end
                        ST_BRK: begin
                            if (w_byte == KEY_F12) begin
                                r_nbreak <= 1'b1;
                            end else if (w_hit) begin
                                r_matrix[w_col][w_row] <= 1'b0;
                            end
                            r_state <= ST_IDLE;
                        end
                        ST_EXT: begin
                            if (w_byte == BYTE_F0) begin
                                r_state <= ST_EXT_BRK;
                            end else if (w_byte != BYTE_E0) begin
                                if (w_hit) begin
                                    r_matrix[w_col][w_row] <= 1'b1;
                                end
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_EXT_BRK: begin
                            if (w_hit) begin
                                r_matrix[w_col][w_row] <= 1'b0;
                            end
                            r_state <= ST_IDLE;
                        end
                        ST_SKIP: begin
                            if (r_skip_cnt <= 3'd1) begin
                                r_state    <= ST_IDLE;
                                r_skip_cnt <= '0;
                            end else begin
                                r_skip_cnt <= r_skip_cnt - 3'd1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end else if (r_state != ST_IDLE) begin
                if (r_tmo_cnt == TIMEOUT - 16'd1) begin
                    r_state    <= ST_IDLE;
                    r_skip_cnt <= '0;
                    r_tmo_cnt  <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                end
            end
        end
    end

    assign nBREAK = r_nbreak;

    logic [NUM_ROWS-1:0] w_col_bits;
    logic                w_col_valid;
    logic [2:0]          w_dip_idx;
    logic                w_any;

    assign w_col_valid = kb.KB_COL < 4'(NUM_COLS);
    assign w_dip_idx   = kb.KB_COL[2:0] - 3'd2;

    always_comb begin
        w_col_bits = '0;
        w_any      = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (kb.KB_COL == 4'(c)) begin
                w_col_bits = r_matrix[c];
            end
            w_any = w_any | (|r_matrix[c][NUM_ROWS-1:1]);
        end
    end

    // Row 0 columns 2..9 are link settings, read live and never stored.
    always_comb begin
        kb.KEY_PRESSED = 1'b0;
        if (w_col_valid) begin
            if (kb.KB_ROW == 3'd0 && kb.KB_COL >= 4'd2) begin
                kb.KEY_PRESSED = DIP[w_dip_idx];
            end else begin
                kb.KEY_PRESSED = w_col_bits[kb.KB_ROW];
            end
        end
    end

    assign kb.COL_ACTIVE = w_col_valid & (|w_col_bits[NUM_ROWS-1:1]);
    assign kb.ANY_KEY    = w_any;

endmodule

// File: tb/tb_ps2_bbc_keymatrix.sv
// Directed bench for the PS/2 to BBC key matrix decoder with hand-computed expectations.
module tb_ps2_bbc_keymatrix;
    localparam logic [15:0] TMO = 16'd40;

    logic       clk    = 1'b0;
    logic       nRESET = 1'b0;
    logic       clk_en = 1'b1;
    logic [7:0] DIP    = 8'hA5;
    logic       nBREAK;
    logic [7:0] dip_exp;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_bbc_keymatrix_if kb_if ();

    ps2_bbc_keymatrix #(.TIMEOUT(TMO)) dut (
        .clk    (clk),
        .nRESET (nRESET),
        .clk_en (clk_en),
        .DIP    (DIP),
        .nBREAK (nBREAK),
        .kb     (kb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        kb_if.PS2_DATA = b;
        kb_if.PS2_DONE = 1'b1;
        @(negedge clk);
        kb_if.PS2_DONE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input int r, input int c);
        @(negedge clk);
        kb_if.KB_ROW = 3'(r);
        kb_if.KB_COL = 4'(c);
        #1;
    endtask

    task automatic chk_key(input string tag, input int r, input int c, input logic exp);
        peek(r, c);
        chk(tag, kb_if.KEY_PRESSED, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dip_exp        = 8'hA5;
        kb_if.PS2_DATA = 8'h00;
        kb_if.PS2_DONE = 1'b0;
        kb_if.KB_COL   = 4'd0;
        kb_if.KB_ROW   = 3'd0;
        idle(3);
        nRESET = 1'b1;

        // Reset state
        peek(0, 1);
        chk("rst_nbreak", nBREAK, 1'b1);
        chk("rst_any", kb_if.ANY_KEY, 1'b0);
        chk("rst_col1_active", kb_if.COL_ACTIVE, 1'b0);
        chk_key("rst_a", 4, 1, 1'b0);
        chk_key("rst_shift", 0, 0, 1'b0);
        for (int c = 2; c < 10; c++)
            chk_key($sformatf("dip_col%0d", c), 0, c, dip_exp[c-2]);

        // A make / break
        send(8'h1C);
        chk_key("a_make", 4, 1, 1'b1);
        chk("a_make_colact", kb_if.COL_ACTIVE, 1'b1);
        chk("a_make_any", kb_if.ANY_KEY, 1'b1);
        send(8'hF0); send(8'h1C);
        chk_key("a_break", 4, 1, 1'b0);
        chk("a_break_colact", kb_if.COL_ACTIVE, 1'b0);

        // SHIFT via left, released via right
        send(8'h12);
        chk_key("shift_make", 0, 0, 1'b1);
        chk("shift_make_any", kb_if.ANY_KEY, 1'b0);
        send(8'hF0); send(8'h59);
        chk_key("shift_break", 0, 0, 1'b0);
        chk("shift_break_any", kb_if.ANY_KEY, 1'b0);

        // Right CTRL via extended code
        send(8'hE0); send(8'h14);
        chk_key("ctrl_ext_make", 0, 1, 1'b1);
        send(8'hF0); send(8'h14);
        chk_key("ctrl_break", 0, 1, 1'b0);

        // Cursor up vs keypad 8
        send(8'hE0); send(8'h75);
        chk_key("up_make", 3, 9, 1'b1);
        send(8'h75);
        chk_key("kp8_make", 1, 5, 1'b1);
        chk_key("up_kept", 3, 9, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_key("up_break", 3, 9, 1'b0);
        chk_key("kp8_kept", 1, 5, 1'b1);
        send(8'hF0); send(8'h75);
        chk_key("kp8_break", 1, 5, 1'b0);
        send(8'hE0); send(8'hE0); send(8'h75);
        chk_key("up_double_e0", 3, 9, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_key("up_break2", 3, 9, 1'b0);

        // Pause sequence swallowed, decoding resumes in IDLE afterwards
        send(8'h1C);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk_key("pause_no_ctrl", 0, 1, 1'b0);
        chk_key("pause_a_held", 4, 1, 1'b1);
        send(8'h29);
        chk_key("pause_then_space", 6, 2, 1'b1);

        // Overrun clears everything including BREAK
        send(8'h07);
        peek(6, 2);
        chk("f12_held_nbreak", nBREAK, 1'b0);
        send(8'h00);
        chk_key("err00_a", 4, 1, 1'b0);
        chk_key("err00_space", 6, 2, 1'b0);
        chk("err00_any", kb_if.ANY_KEY, 1'b0);
        chk("err00_nbreak", nBREAK, 1'b1);

        // FF discards a pending E0 prefix
        send(8'hE0); send(8'hFF); send(8'h75);
        chk_key("errff_kp8", 1, 5, 1'b1);
        chk_key("errff_no_up", 3, 9, 1'b0);
        send(8'hF0); send(8'h75);

        // F12 make / break
        send(8'h07);
        peek(0, 0);
        chk("f12_make", nBREAK, 1'b0);
        send(8'hF0); send(8'h07);
        peek(0, 0);
        chk("f12_break", nBREAK, 1'b1);

        // Timeout: one cycle short keeps the break prefix, exact count drops it
        send(8'h29);
        chk_key("tmo_space_set", 6, 2, 1'b1);
        send(8'hF0); idle(int'(TMO) - 1); send(8'h29);
        chk_key("tmo_short_break", 6, 2, 1'b0);
        send(8'hF0); idle(int'(TMO)); send(8'h29);
        chk_key("tmo_expired_make", 6, 2, 1'b1);
        send(8'hF0); send(8'h29);
        chk_key("tmo_after_break", 6, 2, 1'b0);

        // Reset mid-sequence discards F0
        send(8'h29);
        send(8'hF0);
        nRESET = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;
        send(8'h29);
        chk_key("rst_mid_space", 6, 2, 1'b1);
        send(8'hF0); send(8'h29);

        // Clock enable gating
        clk_en         = 1'b0;
        kb_if.PS2_DATA = 8'h29;
        kb_if.PS2_DONE = 1'b1;
        idle(3);
        chk_key("clken_low_hold", 6, 2, 1'b0);
        clk_en = 1'b1;
        @(negedge clk);
        kb_if.PS2_DONE = 1'b0;
        chk_key("clken_one_byte", 6, 2, 1'b1);
        send(8'hF0); send(8'h29);
        chk_key("clken_break", 6, 2, 1'b0);

        // Out-of-range column
        send(8'h1C); send(8'h29);
        chk_key("col12_row4", 4, 12, 1'b0);
        chk("col12_colact", kb_if.COL_ACTIVE, 1'b0);
        chk_key("col12_row0", 0, 12, 1'b0);
        chk_key("col10_row0", 0, 10, 1'b0);
        chk("col10_any", kb_if.ANY_KEY, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_bbc_keymatrix.md
# ps2_bbc_keymatrix

Consumes the byte stream from the PS/2 receiver (one strobe per received scan code byte) and decodes PS/2 scan code set 2 make/break sequences. It maintains the 10-column by 8-row BBC keyboard switch matrix as a register array, which the system VIA keyboard logic addresses by column/row. It also provides the BREAK key and the column-activity signal used for the keyboard interrupt.

## Interface
- `TIMEOUT`, default `16'hFFFF`: `clk_en` cycles a partial prefix sequence may stay pending before the decoder abandons it.
- `clk` in 1: system clock.
- `nRESET` in 1: reset, synchronous, active-low.
- `clk_en` in 1: clock enable. It qualifies every state update; nothing changes while low.
- `PS2_DATA` in 8: received byte, valid while `PS2_DONE` is high.
- `PS2_DONE` in 1: byte ready. The byte is consumed on every `clk` where `clk_en & PS2_DONE` is true.
- `DIP` in 8: keyboard link settings. They appear at row 0, columns 2..9 (bit n is column n+2); 1 reads as pressed.
- `KB_COL` in 4: column address, 0..9. Values 10..15 select no column.
- `KB_ROW` in 3: row address, 0..7.
- `KEY_PRESSED` out 1: matrix bit at (`KB_ROW`, `KB_COL`). Combinational from registers.
- `COL_ACTIVE` out 1: any key pressed in column `KB_COL`, rows 1..7. Combinational.
- `ANY_KEY` out 1: any key pressed in rows 1..7, any column. Combinational.
- `nBREAK` out 1: low while the BREAK key (PS/2 F12, code 07) is held. Registered.

## Operation
- The matrix holds 80 bits of key state. DIP bits are muxed in at read time and never stored.
- Decoder FSM states:
  - IDLE: 0xF0 goes to BRK; 0xE0 goes to EXT; 0xE1 goes to SKIP with skip count 7. A lookup-hit code sets its bit and returns to IDLE.
  - BRK: a code clears its bit (a miss does nothing), then returns to IDLE.
  - EXT: 0xF0 goes to EXT_BRK. Any other code does an extended lookup, sets its bit, and returns to IDLE.
  - EXT_BRK: does an extended lookup, clears the bit, and returns to IDLE.
  - SKIP: decrements the count on each byte and returns to IDLE when the count reaches 0. This swallows the Pause sequence.
- Special bytes:
  - 0x00 and 0xFF (keyboard overrun/error), in any state: clear the whole matrix, set `nBREAK`=1, go to IDLE.
  - 0xAA, 0xFA and 0xFE in IDLE: ignored.
  - 0xE0 while in EXT: stays in EXT.
- Lookups that miss leave the matrix unchanged.
- Row 0, columns 0..1 are SHIFT (PS/2 0x12 and 0x59 both map here) and CTRL (0x14 and E0 14). Both shift keys share one bit, and releasing either clears it.
- Timeout: an 16-bit counter counts `clk_en` cycles spent in BRK, EXT, EXT_BRK or SKIP without a byte. When it reaches `TIMEOUT`, the FSM goes to IDLE. The counter reloads on each byte.

## Timing
- A byte consumed at cycle N is visible on the matrix outputs at N+1. `nBREAK` also updates at N+1.
- `KEY_PRESSED`, `COL_ACTIVE` and `ANY_KEY` follow address changes within the same cycle (zero latency).
- Reset values:
  - matrix all 0, FSM in IDLE, skip count 0, timeout counter 0;
  - `nBREAK`=1;
  - `KEY_PRESSED`: equals the DIP bit when row 0, columns 2..9 are addressed, otherwise 0;
  - `COL_ACTIVE`=0, `ANY_KEY`=0.
- A reset asserted mid-sequence (for example after 0xF0) discards the prefix. The next byte is decoded from IDLE.
- `PS2_DONE` held high across several `clk` cycles with `clk_en` low consumes no byte. Each `clk_en` cycle with `PS2_DONE` high consumes exactly one byte.
- Repeated make codes (typematic) are idempotent.

## Structure
- Shared package contents:
  - FSM state encoding;
  - matrix dimensions (10 columns, 8 rows);
  - special byte constants (F0, E0, E1, AA, FA, FE, 00, FF);
  - F12 code 0x07.
- The lookup is a sub-module, `ps2_bbc_scancode_map`. It is purely combinational: `{ext, code}` in, `{hit, row[2:0], col[3:0]}` out. It holds the full set-2 to BBC table.
- The matrix array, FSM, counters and read muxes live in the top module.

## Test plan
- Make then break of A: bytes 1C, then F0 1C. Matrix (4,1) reads 1 after 1C and 0 after F0 1C. `COL_ACTIVE` with `KB_COL`=1 follows the same pattern.
- SHIFT: bytes 12, then F0 59. (0,0) reads 1 after 12 and 0 after F0 59. `ANY_KEY` stays 0 throughout (row 0 excluded).
- Extended cursor up: bytes E0 75. (3,9) is set. Then bytes 75 alone, which sets the keypad 8 mapping instead and leaves (3,9) unchanged. Then E0 F0 75 clears (3,9).
- Pause and error handling:
  - E1 14 77 E1 F0 14 F0 77 leaves the matrix unchanged.
  - With keys held, byte 00 clears all keys.
  - F12 make drives `nBREAK` 0; F12 break returns it to 1.
- Timeout and reset:
  - Byte F0, then `TIMEOUT` idle `clk_en` cycles, then 29: Space (6,2) is set, not cleared.
  - Byte F0, then `nRESET` low for 1 cycle, then 29: (6,2) is set.
- DIP and addressing:
  - `DIP`=8'hA5 reads back at row 0, columns 2..9.
  - `KB_COL`=12 gives `KEY_PRESSED`=0 and `COL_ACTIVE`=0 regardless of matrix state.
